decode_execute_register: RTL and testbench
==========================================

// Module: decode_execute_register
// PURPOSE
// Decode->execute pipeline register with operand forwarding and load-use hazard detection. Captures
// decoded instruction fields each cycle and resolves rs1/rs2 against the memory and writeback stages.
// Drives ALU_Control, SrcA and SrcB of the arithmetic_logic_unit combinationally from those registers.
// Also drives the store data and control bits carried to the execute/memory register.
// PARAMETERS
// XLEN  32  datapath width (only 32 supported)
// PORTS
// CLK             in   1     clock, all state updates on posedge
// RST_N           in   1     synchronous reset, active-low
// Stall_E         in   1     hold EX register (memory-side stall)
// Flush_E         in   1     replace EX contents with bubble (taken branch/jump)
// Valid_D         in   1     decode slot holds a real instruction
// PC_D            in   32    decode PC
// RS1_Addr_D      in   5     source register 1 index
// RS2_Addr_D      in   5     source register 2 index
// RD_Addr_D       in   5     destination register index
// RS1_Data_D      in   32    register-file read data for rs1
// RS2_Data_D      in   32    register-file read data for rs2
// Imm_D           in   32    sign-extended immediate
// ALU_Control_D   in   4     ALU opcode (definitions alu enum)
// SrcA_Sel_D      in   1     0 = rs1, 1 = PC
// SrcB_Sel_D      in   1     0 = rs2, 1 = immediate
// Ctrl_D          in   5     {Reg_Write, Mem_Read, Mem_Write, Branch, Jump}
// RD_Addr_M       in   5     memory-stage destination index
// Reg_Write_M     in   1     memory-stage writes a register
// ALU_Result_M    in   32    memory-stage ALU result
// RD_Addr_W       in   5     writeback destination index
// Reg_Write_W     in   1     writeback writes a register
// Result_W        in   32    writeback data
// ALU_Control_E   out  4     to ALU
// SrcA_E          out  32    to ALU
// SrcB_E          out  32    to ALU
// Store_Data_E    out  32    forwarded rs2, for stores
// PC_E            out  32    execute PC
// RD_Addr_E       out  5     destination index
// Ctrl_E          out  5     registered Ctrl_D, zero when bubble
// Valid_E         out  1     execute slot holds a real instruction
// Stall_D         out  1     hold fetch/decode this cycle
// BEHAVIOUR
// - Latency: 1 cycle D->E. All E outputs are registered except SrcA_E, SrcB_E and Store_Data_E.
// - Reset (RST_N=0 at posedge): all registers clear to 0 (ALU_Control_E=ALU_ADD), so Valid_E=0 and Ctrl_E=0.
// - Update priority at each posedge: reset > Flush_E (bubble) > Stall_E (hold) > Load_Use (bubble) > capture.
// - A bubble sets Valid_E, Ctrl_E, RD_Addr_E and ALU_Control_E to 0; the data fields are don't-care.
// - Load_Use is combinational and is true only when all of the following hold:
//     Valid_E, Ctrl_E.Mem_Read, RD_Addr_E != 0 and Valid_D;
//     RD_Addr_E matches a used source. rs1 is used when SrcA_Sel_D=0.
//     rs2 is used when SrcB_Sel_D=0, or Mem_Write_D, or Branch_D.
// - Stall_D = (Stall_E | Load_Use) & ~Flush_E.
// - Capture bypass: if Reg_Write_W & RD_Addr_W != 0 & RD_Addr_W == RSx_Addr_D, the captured RSx data is Result_W.
// - Stall refresh: during a hold, a W write that matches RSx_Addr_E (nonzero) updates the held RSx data.
//   This keeps forwarded values correct across multi-cycle stalls.
// - Forwarding: combinational, per source, for the registered RS1/RS2_Addr_E.
//   Priority is MEM (Reg_Write_M, RD_Addr_M match) > WB (Reg_Write_W, RD_Addr_W match) > held data.
//   Index x0 is never forwarded.
// - SrcA_E = SrcA_Sel_E ? PC_E : fwdA; SrcB_E = SrcB_Sel_E ? Imm_E : fwdB; Store_Data_E = fwdB.
// - Flush_E with Stall_E: flush wins and Stall_D=0. Flush_E with Load_Use: bubble and Stall_D=0.
// - Arithmetic: none. Pure muxing; widths are exact with no extension.
// STRUCTURE
// - definitions package: add fwd_sel_t {FWD_NONE, FWD_MEM, FWD_WB}, srca_sel_t {SRCA_REG, SRCA_PC}
//   and srcb_sel_t {SRCB_REG, SRCB_IMM}.
// - definitions package: add packed struct ctrl_t {Reg_Write, Mem_Read, Mem_Write, Branch, Jump}.
// - Sub-module forwarding_unit (combinational): inputs are the RS addresses and the M/W destinations;
//   outputs are two fwd_sel_t. Instantiate it once.
// - Pipeline register state, bubble/hold logic and hazard detection stay in this module.
// TESTING
// 1 Reset: RST_N=0 with Valid_D=1, Ctrl_D=5'b10000 -> next cycle Valid_E=0, Ctrl_E=0, Stall_D=0.
// 2 Capture: PC_D=0x100, RS1_Data_D=5, Imm_D=7, SrcB_Sel_D=1, ALU_ADD
//   -> next cycle SrcA_E=5, SrcB_E=7, PC_E=0x100, Valid_E=1.
// 3 Forward priority: RS1_Addr_E=3, RD_M=3/0xAAAA, RD_W=3/0xBBBB, both writing -> SrcA_E=0xAAAA.
//   Drop Reg_Write_M -> SrcA_E=0xBBBB.
//   x0 case: RS1_Addr_E=0, RD_M=0, ALU_Result_M=0xDEAD -> SrcA_E=0.
// 4 Load-use: EX holds lw x5, D holds add x6,x5,x1 -> Stall_D=1 for exactly 1 cycle, then Valid_E=0.
//   Next cycle the add is captured and SrcA_E takes the load data via WB forward (Result_W).
// 5 Stall refresh: Stall_E=1 for 3 cycles, RS2_Addr_E=2, W writes x2=0x1234 in cycle 2
//   -> E outputs hold; after release SrcB_E=0x1234 with W idle.
// 6 Flush_E=1 with Stall_E=1 and Load_Use=1 -> next cycle Valid_E=0, Ctrl_E=0; Stall_D=0 that cycle.

Source files
------------

// File: rtl/decode_execute_register_pkg.sv
// Shared types for the decode->execute pipeline register: ALU opcodes, source selects,
// forwarding selects and the packed control bundle carried down the pipe.
package decode_execute_register_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    SRCA_REG = 1'b0,
    SRCA_PC  = 1'b1
  } srca_sel_t;

  typedef enum logic {
    SRCB_REG = 1'b0,
    SRCB_IMM = 1'b1
  } srcb_sel_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(5'b00000);

  // A later stage supplies rs when it writes a nonzero index equal to rs (x0 is hardwired).
  function automatic logic reg_hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
    return wr && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/decode_execute_register_forwarding_unit.sv
// Chooses the source of each execute-stage operand: MEM result, WB result, or held register data.
// MEM is the younger producer, so it wins over WB.
module forwarding_unit
  import decode_execute_register_pkg::*;
(
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic [4:0] rd_addr_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_addr_w,
  input  logic       reg_write_w,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);

  // Per-source priority select.
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (reg_hit(reg_write_m, rd_addr_m, rs1_addr)) begin
      fwd_a = FWD_MEM;
    end else if (reg_hit(reg_write_w, rd_addr_w, rs1_addr)) begin
      fwd_a = FWD_WB;
    end else begin
      fwd_a = FWD_NONE;
    end
    if (reg_hit(reg_write_m, rd_addr_m, rs2_addr)) begin
      fwd_b = FWD_MEM;
    end else if (reg_hit(reg_write_w, rd_addr_w, rs2_addr)) begin
      fwd_b = FWD_WB;
    end else begin
      fwd_b = FWD_NONE;
    end
  end

endmodule

// File: rtl/decode_execute_register.sv
// Decode->execute pipeline register with operand forwarding and load-use hazard detection.
// ALU operands and store data are muxed combinationally from the registered fields.
module decode_execute_register
  import decode_execute_register_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            Stall_E,
  input  logic            Flush_E,
  input  logic            Valid_D,
  input  logic [XLEN-1:0] PC_D,
  input  logic [4:0]      RS1_Addr_D,
  input  logic [4:0]      RS2_Addr_D,
  input  logic [4:0]      RD_Addr_D,
  input  logic [XLEN-1:0] RS1_Data_D,
  input  logic [XLEN-1:0] RS2_Data_D,
  input  logic [XLEN-1:0] Imm_D,
  input  logic [3:0]      ALU_Control_D,
  input  logic            SrcA_Sel_D,
  input  logic            SrcB_Sel_D,
  input  logic [4:0]      Ctrl_D,
  input  logic [4:0]      RD_Addr_M,
  input  logic            Reg_Write_M,
  input  logic [XLEN-1:0] ALU_Result_M,
  input  logic [4:0]      RD_Addr_W,
  input  logic            Reg_Write_W,
  input  logic [XLEN-1:0] Result_W,
  output logic [3:0]      ALU_Control_E,
  output logic [XLEN-1:0] SrcA_E,
  output logic [XLEN-1:0] SrcB_E,
  output logic [XLEN-1:0] Store_Data_E,
  output logic [XLEN-1:0] PC_E,
  output logic [4:0]      RD_Addr_E,
  output logic [4:0]      Ctrl_E,
  output logic            Valid_E,
  output logic            Stall_D
);

  logic            valid_e_r;
  ctrl_t           ctrl_e_r;
  logic [4:0]      rd_addr_e_r;
  logic [3:0]      alu_control_e_r;
  logic [XLEN-1:0] pc_e_r;
  logic [XLEN-1:0] imm_e_r;
  logic [4:0]      rs1_addr_e_r;
  logic [4:0]      rs2_addr_e_r;
  logic [XLEN-1:0] rs1_data_e_r;
  logic [XLEN-1:0] rs2_data_e_r;
  srca_sel_t       srca_sel_e_r;
  srcb_sel_t       srcb_sel_e_r;

  ctrl_t           ctrl_d_s;
  logic            rs1_used_s;
  logic            rs2_used_s;
  logic            load_use_s;
  fwd_sel_t        fwd_a_s;
  fwd_sel_t        fwd_b_s;
  logic [XLEN-1:0] fwd_a_data_s;
  logic [XLEN-1:0] fwd_b_data_s;

  assign ctrl_d_s = ctrl_t'(Ctrl_D);

  // Load-use hazard: a load in EX feeds a source the decode instruction actually reads.
  always_comb begin
    rs1_used_s = (srca_sel_t'(SrcA_Sel_D) == SRCA_REG);
    rs2_used_s = (srcb_sel_t'(SrcB_Sel_D) == SRCB_REG) || ctrl_d_s.mem_write || ctrl_d_s.branch;
    load_use_s = 1'b0;
    if (valid_e_r && ctrl_e_r.mem_read && (rd_addr_e_r != 5'd0) && Valid_D) begin
      load_use_s = (rs1_used_s && (rd_addr_e_r == RS1_Addr_D)) ||
                   (rs2_used_s && (rd_addr_e_r == RS2_Addr_D));
    end else begin
      load_use_s = 1'b0;
    end
    Stall_D = (Stall_E | load_use_s) & ~Flush_E;
  end

  // EX register: reset > flush bubble > hold (with WB refresh) > load-use bubble > capture.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid_e_r       <= 1'b0;
      ctrl_e_r        <= CTRL_BUBBLE;
      rd_addr_e_r     <= 5'd0;
      alu_control_e_r <= ALU_ADD;
      pc_e_r          <= {XLEN{1'b0}};
      imm_e_r         <= {XLEN{1'b0}};
      rs1_addr_e_r    <= 5'd0;
      rs2_addr_e_r    <= 5'd0;
      rs1_data_e_r    <= {XLEN{1'b0}};
      rs2_data_e_r    <= {XLEN{1'b0}};
      srca_sel_e_r    <= SRCA_REG;
      srcb_sel_e_r    <= SRCB_REG;
    end else if (Flush_E || (!Stall_E && load_use_s)) begin
      valid_e_r       <= 1'b0;
      ctrl_e_r        <= CTRL_BUBBLE;
      rd_addr_e_r     <= 5'd0;
      alu_control_e_r <= ALU_ADD;
    end else if (Stall_E) begin
      // The held operands must not go stale while WB retires their producer.
      if (reg_hit(Reg_Write_W, RD_Addr_W, rs1_addr_e_r)) rs1_data_e_r <= Result_W;
      if (reg_hit(Reg_Write_W, RD_Addr_W, rs2_addr_e_r)) rs2_data_e_r <= Result_W;
    end else begin
      valid_e_r       <= Valid_D;
      ctrl_e_r        <= ctrl_d_s;
      rd_addr_e_r     <= RD_Addr_D;
      alu_control_e_r <= ALU_Control_D;
      pc_e_r          <= PC_D;
      imm_e_r         <= Imm_D;
      rs1_addr_e_r    <= RS1_Addr_D;
      rs2_addr_e_r    <= RS2_Addr_D;
      rs1_data_e_r    <= reg_hit(Reg_Write_W, RD_Addr_W, RS1_Addr_D) ? Result_W : RS1_Data_D;
      rs2_data_e_r    <= reg_hit(Reg_Write_W, RD_Addr_W, RS2_Addr_D) ? Result_W : RS2_Data_D;
      srca_sel_e_r    <= srca_sel_t'(SrcA_Sel_D);
      srcb_sel_e_r    <= srcb_sel_t'(SrcB_Sel_D);
    end
  end

  forwarding_unit u_forwarding_unit (
    .rs1_addr    (rs1_addr_e_r),
    .rs2_addr    (rs2_addr_e_r),
    .rd_addr_m   (RD_Addr_M),
    .reg_write_m (Reg_Write_M),
    .rd_addr_w   (RD_Addr_W),
    .reg_write_w (Reg_Write_W),
    .fwd_a       (fwd_a_s),
    .fwd_b       (fwd_b_s)
  );

  // Operand muxing from forwarded data, PC and immediate.
  always_comb begin
    case (fwd_a_s)
      FWD_MEM: fwd_a_data_s = ALU_Result_M;
      FWD_WB:  fwd_a_data_s = Result_W;
      default: fwd_a_data_s = rs1_data_e_r;
    endcase
    case (fwd_b_s)
      FWD_MEM: fwd_b_data_s = ALU_Result_M;
      FWD_WB:  fwd_b_data_s = Result_W;
      default: fwd_b_data_s = rs2_data_e_r;
    endcase
    if (srca_sel_e_r == SRCA_PC) begin
      SrcA_E = pc_e_r;
    end else begin
      SrcA_E = fwd_a_data_s;
    end
    if (srcb_sel_e_r == SRCB_IMM) begin
      SrcB_E = imm_e_r;
    end else begin
      SrcB_E = fwd_b_data_s;
    end
    Store_Data_E = fwd_b_data_s;
  end

  assign ALU_Control_E = alu_control_e_r;
  assign PC_E          = pc_e_r;
  assign RD_Addr_E     = rd_addr_e_r;
  assign Ctrl_E        = ctrl_e_r;
  assign Valid_E       = valid_e_r;

endmodule

// File: tb/tb_decode_execute_register.sv
// Bench for decode_execute_register: directed table, hand-written hazard sequences and a
// randomized run, all compared against an instruction-level model of the EX slot.
module tb_decode_execute_register;
  import decode_execute_register_pkg::*;

  logic        CLK;
  logic        RST_N, Stall_E, Flush_E, Valid_D;
  logic [31:0] PC_D, RS1_Data_D, RS2_Data_D, Imm_D;
  logic [4:0]  RS1_Addr_D, RS2_Addr_D, RD_Addr_D, Ctrl_D;
  logic [3:0]  ALU_Control_D;
  logic        SrcA_Sel_D, SrcB_Sel_D;
  logic [4:0]  RD_Addr_M, RD_Addr_W;
  logic        Reg_Write_M, Reg_Write_W;
  logic [31:0] ALU_Result_M, Result_W;
  logic [3:0]  ALU_Control_E;
  logic [31:0] SrcA_E, SrcB_E, Store_Data_E, PC_E;
  logic [4:0]  RD_Addr_E, Ctrl_E;
  logic        Valid_E, Stall_D;

  decode_execute_register #(.XLEN(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .Stall_E(Stall_E), .Flush_E(Flush_E), .Valid_D(Valid_D),
    .PC_D(PC_D), .RS1_Addr_D(RS1_Addr_D), .RS2_Addr_D(RS2_Addr_D), .RD_Addr_D(RD_Addr_D),
    .RS1_Data_D(RS1_Data_D), .RS2_Data_D(RS2_Data_D), .Imm_D(Imm_D),
    .ALU_Control_D(ALU_Control_D), .SrcA_Sel_D(SrcA_Sel_D), .SrcB_Sel_D(SrcB_Sel_D),
    .Ctrl_D(Ctrl_D), .RD_Addr_M(RD_Addr_M), .Reg_Write_M(Reg_Write_M),
    .ALU_Result_M(ALU_Result_M), .RD_Addr_W(RD_Addr_W), .Reg_Write_W(Reg_Write_W),
    .Result_W(Result_W), .ALU_Control_E(ALU_Control_E), .SrcA_E(SrcA_E), .SrcB_E(SrcB_E),
    .Store_Data_E(Store_Data_E), .PC_E(PC_E), .RD_Addr_E(RD_Addr_E), .Ctrl_E(Ctrl_E),
    .Valid_E(Valid_E), .Stall_D(Stall_D)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction sitting in the execute slot, as the model sees it.
  typedef struct packed {
    logic        valid;
    logic [4:0]  ctrl;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        sa;
    logic        sb;
  } ex_t;
  ex_t m;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  a1, a2, rd;
    logic [31:0] d1, d2, imm;
    logic [3:0]  alu;
    logic        sa, sb;
    logic [4:0]  ctrl;
    logic [31:0] e_srca, e_srcb, e_store;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd_exp(input logic [4:0] a, input logic [31:0] held);
    if (a != 5'd0 && Reg_Write_M && RD_Addr_M == a) return ALU_Result_M;
    if (a != 5'd0 && Reg_Write_W && RD_Addr_W == a) return Result_W;
    return held;
  endfunction

  function automatic logic w_writes(input logic [4:0] a);
    return Reg_Write_W && RD_Addr_W != 5'd0 && RD_Addr_W == a;
  endfunction

  function automatic logic load_use_exp();
    logic uses1, uses2;
    uses1 = !SrcA_Sel_D && RS1_Addr_D == m.rd;
    uses2 = (!SrcB_Sel_D || Ctrl_D[2] || Ctrl_D[1]) && RS2_Addr_D == m.rd;
    return m.valid && m.ctrl[3] && m.rd != 5'd0 && Valid_D && (uses1 || uses2);
  endfunction

  // Compare against the model, then advance the model across one rising edge.
  task automatic tick();
    ex_t n;
    logic lu;
    #1;
    lu = load_use_exp();
    chk("Stall_D", 32'(Stall_D), 32'((Stall_E | lu) & ~Flush_E));
    chk("Valid_E", 32'(Valid_E), 32'(m.valid));
    chk("Ctrl_E", 32'(Ctrl_E), 32'(m.ctrl));
    chk("RD_Addr_E", 32'(RD_Addr_E), 32'(m.rd));
    chk("ALU_Control_E", 32'(ALU_Control_E), 32'(m.alu));
    if (m.valid) begin
      chk("PC_E", PC_E, m.pc);
      chk("SrcA_E", SrcA_E, m.sa ? m.pc : fwd_exp(m.a1, m.d1));
      chk("SrcB_E", SrcB_E, m.sb ? m.imm : fwd_exp(m.a2, m.d2));
      chk("Store_Data_E", Store_Data_E, fwd_exp(m.a2, m.d2));
    end
    n = m;
    if (!RST_N) begin
      n = '0;
    end else if (Flush_E || (!Stall_E && lu)) begin
      n.valid = 1'b0; n.ctrl = 5'd0; n.rd = 5'd0; n.alu = 4'd0;
    end else if (Stall_E) begin
      if (w_writes(m.a1)) n.d1 = Result_W;
      if (w_writes(m.a2)) n.d2 = Result_W;
    end else begin
      n.valid = Valid_D; n.ctrl = Ctrl_D; n.rd = RD_Addr_D; n.alu = ALU_Control_D;
      n.pc = PC_D; n.imm = Imm_D; n.a1 = RS1_Addr_D; n.a2 = RS2_Addr_D;
      n.sa = SrcA_Sel_D; n.sb = SrcB_Sel_D;
      n.d1 = w_writes(RS1_Addr_D) ? Result_W : RS1_Data_D;
      n.d2 = w_writes(RS2_Addr_D) ? Result_W : RS2_Data_D;
    end
    @(posedge CLK);
    m = n;
    #1;
  endtask

  task automatic d_instr(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [3:0] alu, input logic sa,
                         input logic sb, input logic [4:0] ctrl);
    Valid_D = 1'b1; PC_D = pc; RS1_Addr_D = a1; RS2_Addr_D = a2; RD_Addr_D = rd;
    RS1_Data_D = d1; RS2_Data_D = d2; Imm_D = imm; ALU_Control_D = alu;
    SrcA_Sel_D = sa; SrcB_Sel_D = sb; Ctrl_D = ctrl;
  endtask

  task automatic idle_mw();
    RD_Addr_M = 5'd0; Reg_Write_M = 1'b0; ALU_Result_M = 32'd0;
    RD_Addr_W = 5'd0; Reg_Write_W = 1'b0; Result_W = 32'd0;
  endtask

  initial begin
    vecs[0] = '{32'h100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd9, 32'd7, ALU_ADD, 1'b0, 1'b1,
                5'b10000, 32'd5, 32'd7, 32'd9};
    vecs[1] = '{32'h200, 5'd4, 5'd6, 5'd7, 32'h11, 32'h22, 32'h30, ALU_SUB, 1'b1, 1'b0,
                5'b10000, 32'h200, 32'h22, 32'h22};
    vecs[2] = '{32'h3FC, 5'd8, 5'd9, 5'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFC, ALU_SLL,
                1'b0, 1'b1, 5'b00100, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h8000_0000};
    vecs[3] = '{32'h400, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h1234_5678, ALU_XOR, 1'b1, 1'b1,
                5'b00010, 32'h400, 32'h1234_5678, 32'd0};

    // Reset with a live instruction presented at decode.
    Stall_E = 1'b0; Flush_E = 1'b0; RST_N = 1'b0;
    idle_mw();
    d_instr(32'h40, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd3, ALU_SUB, 1'b0, 1'b0, 5'b10000);
    @(posedge CLK);
    #1;
    m = '0;
    chk("reset Valid_E", 32'(Valid_E), 32'd0);
    chk("reset Ctrl_E", 32'(Ctrl_E), 32'd0);
    chk("reset ALU_Control_E", 32'(ALU_Control_E), 32'(ALU_ADD));
    chk("reset Stall_D", 32'(Stall_D), 32'd0);
    RST_N = 1'b1;

    // Capture table.
    for (int i = 0; i < 4; i++) begin
      d_instr(vecs[i].pc, vecs[i].a1, vecs[i].a2, vecs[i].rd, vecs[i].d1, vecs[i].d2,
              vecs[i].imm, vecs[i].alu, vecs[i].sa, vecs[i].sb, vecs[i].ctrl);
      tick();
      chk("vec Valid_E", 32'(Valid_E), 32'd1);
      chk("vec PC_E", PC_E, vecs[i].pc);
      chk("vec Ctrl_E", 32'(Ctrl_E), 32'(vecs[i].ctrl));
      chk("vec ALU_Control_E", 32'(ALU_Control_E), 32'(vecs[i].alu));
      chk("vec SrcA_E", SrcA_E, vecs[i].e_srca);
      chk("vec SrcB_E", SrcB_E, vecs[i].e_srcb);
      chk("vec Store_Data_E", Store_Data_E, vecs[i].e_store);
    end

    // Forwarding priority and x0.
    d_instr(32'h500, 5'd3, 5'd0, 5'd10, 32'h11, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 5'b10000);
    tick();
    Valid_D = 1'b0;
    RD_Addr_M = 5'd3; Reg_Write_M = 1'b1; ALU_Result_M = 32'hAAAA;
    RD_Addr_W = 5'd3; Reg_Write_W = 1'b1; Result_W = 32'hBBBB;
    #1 chk("fwd MEM over WB", SrcA_E, 32'hAAAA);
    Reg_Write_M = 1'b0;
    #1 chk("fwd WB", SrcA_E, 32'hBBBB);
    idle_mw();
    d_instr(32'h504, 5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 5'b10000);
    tick();
    RD_Addr_M = 5'd0; Reg_Write_M = 1'b1; ALU_Result_M = 32'hDEAD;
    RD_Addr_W = 5'd0; Reg_Write_W = 1'b1; Result_W = 32'hBEEF;
    #1 chk("fwd x0", SrcA_E, 32'd0);
    idle_mw();

    // Load-use: lw x5 in EX, add x6,x5,x1 in decode.
    d_instr(32'h600, 5'd1, 5'd0, 5'd5, 32'd0, 32'd0, 32'd4, ALU_ADD, 1'b0, 1'b1, 5'b11000);
    tick();
    d_instr(32'h604, 5'd5, 5'd1, 5'd6, 32'h999, 32'd1, 32'd0, ALU_ADD, 1'b0, 1'b0, 5'b10000);
    #1 chk("load-use Stall_D", 32'(Stall_D), 32'd1);
    tick();
    chk("load-use bubble Valid_E", 32'(Valid_E), 32'd0);
    chk("load-use stall released", 32'(Stall_D), 32'd0);
    tick();
    RD_Addr_W = 5'd5; Reg_Write_W = 1'b1; Result_W = 32'hCAFE;
    #1;
    chk("load-use add Valid_E", 32'(Valid_E), 32'd1);
    chk("load-use WB fwd", SrcA_E, 32'hCAFE);
    idle_mw();

    // Stall refresh across a 3-cycle hold.
    d_instr(32'h700, 5'd0, 5'd2, 5'd8, 32'd0, 32'h55, 32'd0, ALU_OR, 1'b0, 1'b0, 5'b10000);
    tick();
    d_instr(32'h704, 5'd9, 5'd9, 5'd9, 32'd1, 32'd1, 32'd1, ALU_AND, 1'b0, 1'b0, 5'b10000);
    Stall_E = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        RD_Addr_W = 5'd2; Reg_Write_W = 1'b1; Result_W = 32'h1234;
      end else begin
        idle_mw();
      end
      tick();
      chk("stall hold PC_E", PC_E, 32'h700);
    end
    Stall_E = 1'b0;
    #1;
    chk("stall refresh SrcB_E", SrcB_E, 32'h1234);
    chk("stall refresh Store", Store_Data_E, 32'h1234);
    tick();

    // Flush beats stall and load-use.
    d_instr(32'h800, 5'd1, 5'd0, 5'd5, 32'd0, 32'd0, 32'd4, ALU_ADD, 1'b0, 1'b1, 5'b11000);
    tick();
    d_instr(32'h804, 5'd5, 5'd5, 5'd6, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 5'b10000);
    Stall_E = 1'b1; Flush_E = 1'b1;
    #1 chk("flush Stall_D", 32'(Stall_D), 32'd0);
    tick();
    chk("flush Valid_E", 32'(Valid_E), 32'd0);
    chk("flush Ctrl_E", 32'(Ctrl_E), 32'd0);
    Stall_E = 1'b0; Flush_E = 1'b0;

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      RST_N   = ($urandom_range(0, 99) != 0);
      Stall_E = ($urandom_range(0, 4) == 0);
      Flush_E = ($urandom_range(0, 11) == 0);
      d_instr($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 4'($urandom_range(0, 9)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      Valid_D      = ($urandom_range(0, 3) != 0);
      RD_Addr_M    = 5'($urandom_range(0, 7));
      Reg_Write_M  = 1'($urandom_range(0, 1));
      ALU_Result_M = $urandom;
      RD_Addr_W    = 5'($urandom_range(0, 7));
      Reg_Write_W  = 1'($urandom_range(0, 1));
      Result_W     = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
